// File: rtl/multi_timer.sv
// ============================================================================
// Module   : multi_timer
// Purpose  : NUM_CH independent WIDTH-bit down-counting timers. Each channel
//            runs one-shot or periodic and can be stopped or retriggered.
//            Sticky per-channel expiry flags are masked and ORed into one
//            interrupt line.
// Ports    : clk         system clock, rising edge
//            rst_n       asynchronous active-low reset
//            clr         synchronous global clear
//            start       per-channel start/retrigger strobe
//            stop        per-channel stop strobe (wins over start)
//            periodic    per-channel mode, sampled on start
//            timer_val   per-channel load value, slice i at [i*WIDTH +: WIDTH]
//            irq_mask    per-channel interrupt enable
//            status_ack  per-channel write-1-to-clear for status
//            pulse       one-cycle expiry pulse per channel
//            busy        channel counting
//            remain      remaining count per channel, 0 when idle
//            status      sticky expiry flags
//            irq         |(status & irq_mask), combinational
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_timer #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 21
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic [NUM_CH-1:0]         start,
  input  logic [NUM_CH-1:0]         stop,
  input  logic [NUM_CH-1:0]         periodic,
  input  logic [NUM_CH*WIDTH-1:0]   timer_val,
  input  logic [NUM_CH-1:0]         irq_mask,
  input  logic [NUM_CH-1:0]         status_ack,
  output logic [NUM_CH-1:0]         pulse,
  output logic [NUM_CH-1:0]         busy,
  output logic [NUM_CH*WIDTH-1:0]   remain,
  output logic [NUM_CH-1:0]         status,
  output logic                      irq
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_COUNT = 2'b01
  } state_t;

  localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      state_t           state;
      logic [WIDTH-1:0] cnt;
      logic [WIDTH-1:0] load_val;
      logic             mode;
      logic             pulse_q;
      logic             busy_q;
      logic             status_q;
      logic [WIDTH-1:0] tv;
      logic [WIDTH-1:0] eff_n;

      assign tv    = timer_val[gi*WIDTH +: WIDTH];
      // A load value of zero behaves as one so the channel always expires.
      assign eff_n = (tv == '0) ? C_ONE : tv;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state    <= S_IDLE;
          cnt      <= '0;
          load_val <= '0;
          mode     <= 1'b0;
          pulse_q  <= 1'b0;
          busy_q   <= 1'b0;
          status_q <= 1'b0;
        end else if (clr) begin
          state    <= S_IDLE;
          cnt      <= '0;
          load_val <= '0;
          mode     <= 1'b0;
          pulse_q  <= 1'b0;
          busy_q   <= 1'b0;
          status_q <= 1'b0;
        end else begin
          pulse_q <= 1'b0;
          // Ack first so that a same-edge expiry below overrides it.
          if (status_ack[gi]) begin
            status_q <= 1'b0;
          end
          case (state)
            S_IDLE: begin
              if (start[gi] && !stop[gi]) begin
                load_val <= eff_n;
                mode     <= periodic[gi];
                cnt      <= eff_n;
                state    <= S_COUNT;
                busy_q   <= 1'b1;
              end
            end
            S_COUNT: begin
              if (stop[gi]) begin
                // Stop also swallows an expiry due on this edge.
                cnt    <= '0;
                state  <= S_IDLE;
                busy_q <= 1'b0;
              end else if (start[gi]) begin
                // Retrigger swallows an expiry due on this edge.
                load_val <= eff_n;
                mode     <= periodic[gi];
                cnt      <= eff_n;
              end else if (cnt == C_ONE) begin
                pulse_q  <= 1'b1;
                status_q <= 1'b1;
                if (mode) begin
                  cnt <= load_val;
                end else begin
                  cnt    <= '0;
                  state  <= S_IDLE;
                  busy_q <= 1'b0;
                end
              end else begin
                cnt <= cnt - C_ONE;
              end
            end
            default: begin
              cnt    <= '0;
              state  <= S_IDLE;
              busy_q <= 1'b0;
            end
          endcase
        end
      end

      assign pulse[gi]                 = pulse_q;
      assign busy[gi]                  = busy_q;
      assign status[gi]                = status_q;
      assign remain[gi*WIDTH +: WIDTH] = cnt;
    end
  endgenerate

  assign irq = |(status & irq_mask);

endmodule

`default_nettype wire
